// File: rtl/fix_msg_serializer.sv
// FIX tag/value serializer: turns right-aligned ASCII tag/value pairs into
// "tag=value<SOH>" bytes and closes each message with a "10=NNN<SOH>" trailer.
module fix_msg_serializer #(
  parameter int         TAG_BYTES = 4,
  parameter int         VAL_BYTES = 32,
  parameter logic [7:0] SOH       = 8'h01
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*TAG_BYTES-1:0] tag_i,
  input  logic [8*VAL_BYTES-1:0] value_i,
  input  logic                   last_i,
  input  logic                   pair_valid_i,
  output logic                   pair_ready_o,
  output logic [7:0]             data_o,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic                   msg_done_o,
  output logic                   err_o
);

  localparam int MAX_B0 = (TAG_BYTES > VAL_BYTES) ? TAG_BYTES : VAL_BYTES;
  localparam int MAX_B  = (MAX_B0 > 3) ? MAX_B0 : 3;
  localparam int CW     = $clog2(MAX_B + 1);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] CNT_THREE = CW'(3);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TAG    = 3'd1,
    S_EQ     = 3'd2,
    S_VAL    = 3'd3,
    S_FSOH   = 3'd4,
    S_CK_TAG = 3'd5,
    S_CK_DIG = 3'd6,
    S_CK_SOH = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [8*TAG_BYTES-1:0] tag_q, tag_d;
  logic [8*VAL_BYTES-1:0] val_q, val_d;
  logic                   last_q, last_d;
  logic [CW-1:0]          val_len_q, val_len_d;
  logic [7:0]             csum_q, csum_d;
  logic [7:0]             data_q, data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   msg_done_q, msg_done_d;
  logic                   err_q, err_d;

  logic                   xfer_s;
  logic                   accept_s;
  logic                   body_s;
  logic                   tag_zero_s;
  logic [7:0]             byte_s;

  // Number of significant bytes: position of the highest nonzero byte plus one.
  function automatic logic [CW-1:0] tag_len_f(input logic [8*TAG_BYTES-1:0] v);
    logic [CW-1:0] n;
    n = CNT_ZERO;
    for (int i = 0; i < TAG_BYTES; i++) begin
      if (v[8*i +: 8] != 8'h00) n = CW'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] val_len_f(input logic [8*VAL_BYTES-1:0] v);
    logic [CW-1:0] n;
    n = CNT_ZERO;
    for (int i = 0; i < VAL_BYTES; i++) begin
      if (v[8*i +: 8] != 8'h00) n = CW'(i + 1);
    end
    return n;
  endfunction

  // Byte n-1 (counting from bit 0) of the held field, n being bytes still to send.
  function automatic logic [7:0] tag_byte_f(input logic [8*TAG_BYTES-1:0] v,
                                            input logic [CW-1:0]          n);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < TAG_BYTES; i++) begin
      if (n == CW'(i + 1)) b = v[8*i +: 8];
    end
    return b;
  endfunction

  function automatic logic [7:0] val_byte_f(input logic [8*VAL_BYTES-1:0] v,
                                            input logic [CW-1:0]          n);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < VAL_BYTES; i++) begin
      if (n == CW'(i + 1)) b = v[8*i +: 8];
    end
    return b;
  endfunction

  // ASCII decimal digit of the checksum: n=3 hundreds, n=2 tens, otherwise ones.
  function automatic logic [7:0] digit_f(input logic [7:0] c, input logic [CW-1:0] n);
    logic [7:0] d;
    case (n)
      CNT_THREE: d = c / 8'd100;
      CNT_TWO:   d = (c / 8'd10) % 8'd10;
      default:   d = c % 8'd10;
    endcase
    return 8'h30 + d;
  endfunction

  assign xfer_s       = data_valid_q && data_ready_i;
  assign accept_s     = pair_valid_i && (state_q == S_IDLE);
  assign tag_zero_s   = (tag_i == {(8*TAG_BYTES){1'b0}});
  assign body_s       = (state_q == S_TAG) || (state_q == S_EQ) ||
                        (state_q == S_VAL) || (state_q == S_FSOH);
  assign pair_ready_o = (state_q == S_IDLE);
  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign msg_done_o   = msg_done_q;
  assign err_o        = err_q;

  // State, byte counter, held pair and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      tag_q        <= {(8*TAG_BYTES){1'b0}};
      val_q        <= {(8*VAL_BYTES){1'b0}};
      last_q       <= 1'b0;
      val_len_q    <= CNT_ZERO;
      csum_q       <= 8'h00;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      msg_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      val_q        <= val_d;
      last_q       <= last_d;
      val_len_q    <= val_len_d;
      csum_q       <= csum_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      msg_done_q   <= msg_done_d;
      err_q        <= err_d;
    end
  end

  // Next state: every non-idle state moves on only when its byte transfers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && !tag_zero_s) begin
          state_d = S_TAG;
          cnt_d   = tag_len_f(tag_i);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TAG: begin
        if (xfer_s && cnt_q == CNT_ONE) begin
          state_d = S_EQ;
        end else if (xfer_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_EQ: begin
        if (xfer_s && val_len_q != CNT_ZERO) begin
          state_d = S_VAL;
          cnt_d   = val_len_q;
        end else if (xfer_s) begin
          state_d = S_FSOH;
        end else begin
          state_d = S_EQ;
        end
      end
      S_VAL: begin
        if (xfer_s && cnt_q == CNT_ONE) begin
          state_d = S_FSOH;
        end else if (xfer_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_FSOH: begin
        if (xfer_s && last_q) begin
          state_d = S_CK_TAG;
          cnt_d   = CNT_THREE;
        end else if (xfer_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FSOH;
        end
      end
      S_CK_TAG: begin
        if (xfer_s && cnt_q == CNT_ONE) begin
          state_d = S_CK_DIG;
          cnt_d   = CNT_THREE;
        end else if (xfer_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CK_DIG: begin
        if (xfer_s && cnt_q == CNT_ONE) begin
          state_d = S_CK_SOH;
        end else if (xfer_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CK_SOH: begin
        if (xfer_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CK_SOH;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Datapath: pair capture, checksum, and the byte presented for the next state.
  always_comb begin
    tag_d        = tag_q;
    val_d        = val_q;
    last_d       = last_q;
    val_len_d    = val_len_q;
    csum_d       = csum_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    msg_done_d   = 1'b0;
    err_d        = 1'b0;
    byte_s       = 8'h00;

    if (accept_s) begin
      tag_d     = tag_i;
      val_d     = value_i;
      last_d    = last_i;
      val_len_d = val_len_f(value_i);
      err_d     = tag_zero_s;
    end else begin
      err_d = 1'b0;
    end

    // The trailer is never summed, so the value is frozen once CK_TAG is entered.
    if (xfer_s && body_s) begin
      csum_d = csum_q + data_q;
    end else if (xfer_s && state_q == S_CK_SOH) begin
      csum_d     = 8'h00;
      msg_done_d = 1'b1;
    end else begin
      csum_d = csum_q;
    end

    case (state_d)
      S_TAG:    byte_s = tag_byte_f(tag_d, cnt_d);
      S_EQ:     byte_s = 8'h3D;
      S_VAL:    byte_s = val_byte_f(val_d, cnt_d);
      S_FSOH:   byte_s = SOH;
      S_CK_TAG: byte_s = (cnt_d == CNT_THREE) ? 8'h31 :
                         (cnt_d == CNT_TWO)   ? 8'h30 : 8'h3D;
      S_CK_DIG: byte_s = digit_f(csum_d, cnt_d);
      S_CK_SOH: byte_s = SOH;
      default:  byte_s = 8'h00;
    endcase

    if (state_q == S_IDLE || xfer_s) begin
      data_d       = byte_s;
      data_valid_d = (state_d != S_IDLE);
    end else begin
      data_d       = data_q;
      data_valid_d = data_valid_q;
    end
  end

endmodule
